// File: rtl/regfile_commit_ctrl_pkg.sv
// Shared constants for the commit controller and anything that talks to it.
// Holds the ROB id width and range, and the controller state encoding. The
// state names are visible to benches through the package import.
package regfile_commit_ctrl_pkg;

  localparam int unsigned ROB_W_DEF = 3;
  localparam int unsigned ROB_RANGE = 1 << ROB_W_DEF;

  // RUN accepts commits, FLUSH emits the redirect, WAIT holds off new commits
  typedef enum logic [1:0] {
    RUN   = 2'd0,
    FLUSH = 2'd1,
    WAIT  = 2'd2
  } state_t;

endpackage

// File: rtl/regfile_commit_ctrl.sv
// regfile_commit_ctrl: retires the ROB head into the register file and turns
// a mispredicted head into a one-cycle global flush with a redirect PC,
// followed by FLUSH_WAIT quiet cycles before commits resume.
//
// Ports:
//   clk_in, rst_in (async, active-low), rdy_in (global enable, low freezes)
//   rob_*_in / rob_ready_out     : ROB head handshake and payload
//   to_regfile_*                 : registered regfile write port
//   flush_out / flush_pc_out     : registered flush pulse and redirect PC
//   commit_count_out             : accepted-entry counter, only present when
//                                  the COMMIT_COUNTER_EN macro is defined
module regfile_commit_ctrl
  import regfile_commit_ctrl_pkg::*;
#(
  parameter int unsigned ROB_W      = ROB_W_DEF,
  parameter int unsigned FLUSH_WAIT = 2
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             rdy_in,
  input  logic             rob_valid_in,
  output logic             rob_ready_out,
  input  logic [4:0]       rob_reg_id_in,
  input  logic [31:0]      rob_data_in,
  input  logic [ROB_W-1:0] rob_rob_id_in,
  input  logic             rob_mispredict_in,
  input  logic [31:0]      rob_target_pc_in,
  output logic             to_regfile_write_enabled,
  output logic [4:0]       to_regfile_reg_id,
  output logic [31:0]      to_regfile_data,
  output logic [ROB_W-1:0] to_regfile_rob_id,
`ifdef COMMIT_COUNTER_EN
  output logic [31:0]      commit_count_out,
`endif
  output logic             flush_out,
  output logic [31:0]      flush_pc_out
);

  localparam int unsigned CNT_W = (FLUSH_WAIT < 2) ? 1 : $clog2(FLUSH_WAIT + 1);

  state_t           state;
  logic [CNT_W-1:0] wait_cnt;
  logic [31:0]      target_pc;
  logic             accept;

  assign rob_ready_out = (state == RUN) && rdy_in;
  assign accept        = rob_valid_in && rob_ready_out;

  // Single FSM process; all outputs except rob_ready_out are registered here
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state                    <= RUN;
      wait_cnt                 <= '0;
      target_pc                <= '0;
      to_regfile_write_enabled <= 1'b0;
      to_regfile_reg_id        <= '0;
      to_regfile_data          <= '0;
      to_regfile_rob_id        <= '0;
      flush_out                <= 1'b0;
      flush_pc_out             <= '0;
`ifdef COMMIT_COUNTER_EN
      commit_count_out         <= '0;
`endif
    end else if (!rdy_in) begin
      // Frozen: only the pulse outputs drop so nothing is replayed
      to_regfile_write_enabled <= 1'b0;
      flush_out                <= 1'b0;
    end else begin
      to_regfile_write_enabled <= 1'b0;
      flush_out                <= 1'b0;
      case (state)
        RUN: begin
          if (accept) begin
            // Register 0 is consumed but never written
            to_regfile_write_enabled <= (rob_reg_id_in != 5'd0);
            to_regfile_reg_id        <= rob_reg_id_in;
            to_regfile_data          <= rob_data_in;
            to_regfile_rob_id        <= rob_rob_id_in;
            if (rob_mispredict_in) begin
              target_pc <= rob_target_pc_in;
              state     <= FLUSH;
            end
          end
        end
        FLUSH: begin
          flush_out    <= 1'b1;
          flush_pc_out <= target_pc;
          wait_cnt     <= CNT_W'(FLUSH_WAIT);
          state        <= (FLUSH_WAIT == 0) ? RUN : WAIT;
        end
        WAIT: begin
          // Leaving as the count reaches zero gives exactly FLUSH_WAIT quiet cycles
          wait_cnt <= (wait_cnt == '0) ? '0 : wait_cnt - CNT_W'(1);
          if (wait_cnt <= CNT_W'(1)) begin
            state <= RUN;
          end
        end
        default: begin
          state <= RUN;
        end
      endcase
`ifdef COMMIT_COUNTER_EN
      if (accept) begin
        commit_count_out <= commit_count_out + 32'd1;
      end
`endif
    end
  end

endmodule

// File: doc/regfile_commit_ctrl.md
REGFILE_COMMIT_CTRL -- requirements
Module: regfile_commit_ctrl

Interface
REQ-001 SHALL have parameter ROB_W, default 3, meaning ROB id width (matches the shared ROB range).
REQ-002 SHALL have parameter FLUSH_WAIT, default 2, meaning quiet cycles after a flush pulse before new commits are accepted.
REQ-003 SHALL have port clk_in  input  1  system clock.
REQ-004 SHALL have port rst_in  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port rdy_in  input  1  global enable; low freezes all state.
REQ-006 SHALL have port rob_valid_in  input  1  ROB head entry is ready to commit.
REQ-007 SHALL have port rob_ready_out  output  1  controller accepts the head this cycle.
REQ-008 SHALL have port rob_reg_id_in  input  5  destination register of the head entry.
REQ-009 SHALL have port rob_data_in  input  32  result value.
REQ-010 SHALL have port rob_rob_id_in  input  ROB_W  ROB id of the head entry.
REQ-011 SHALL have port rob_mispredict_in  input  1  head entry is a mispredicted branch.
REQ-012 SHALL have port rob_target_pc_in  input  32  correct PC for a mispredict.
REQ-013 SHALL have ports to_regfile_write_enabled / to_regfile_reg_id / to_regfile_data / to_regfile_rob_id  output  1/5/32/ROB_W  regfile commit write port.
REQ-014 SHALL have ports flush_out / flush_pc_out  output  1/32  global flush pulse and redirect PC.

Function
REQ-015 SHALL implement states RUN, FLUSH, WAIT.
REQ-016 rob_ready_out SHALL equal (state==RUN) && rdy_in, combinationally.
REQ-017 Handshake: entry accepted iff rob_valid_in && rob_ready_out at a rising edge.
REQ-018 Write port outputs SHALL be registered: accepted entry appears on to_regfile_* exactly 1 cycle later, for 1 cycle.
REQ-019 to_regfile_write_enabled SHALL be 0 when the accepted rob_reg_id_in is 0; the entry is still consumed.
REQ-020 to_regfile_write_enabled SHALL be 0 in any cycle following a non-accept edge.
REQ-021 Accepted entry with rob_mispredict_in=1: its write SHALL still occur; state RUN->FLUSH.
REQ-022 In FLUSH: flush_out=1 and flush_pc_out=captured target PC for exactly 1 cycle; then FLUSH->WAIT.
REQ-023 In WAIT: a down-counter loaded with FLUSH_WAIT SHALL decrement each enabled cycle; at 0 WAIT->RUN; FLUSH_WAIT=0 means FLUSH->RUN directly.
REQ-024 flush_out SHALL be 0 in all states except FLUSH; flush_pc_out holds its last value.
REQ-025 rdy_in=0 SHALL hold state, counter and all registered outputs, except to_regfile_write_enabled and flush_out, which SHALL be forced 0 so no write or flush repeats.
REQ-026 Back-to-back accepts in RUN SHALL sustain 1 commit per cycle.

Reset
REQ-027 On rst_in low: state=RUN, counter=0, all outputs 0 (flush_pc_out=0), immediately (asynchronous).
REQ-028 Reset during FLUSH or WAIT SHALL abort the flush sequence; no flush_out after reset release.

Configuration
REQ-029 Macro COMMIT_COUNTER_EN: when defined, SHALL add output commit_count_out [31:0] counting accepted entries (incl. reg 0), wrapping at 2^32, reset 0; when undefined, port and counter SHALL be absent.

Structure
REQ-030 State encoding and ROB_W default SHALL live in the shared constants include (alongside ROB_RANGE); state names shared with bench.
REQ-031 No sub-module; single flat module (optional counter under macro).

Verification
REQ-032 Reset then rob_valid_in=1, reg 5, data 0xDEADBEEF, id 2 -> next cycle write_enabled=1, reg 5, data 0xDEADBEEF, rob_id 2.
REQ-033 Three consecutive valid entries regs 1,2,3 -> three consecutive write cycles, rob_ready_out stays 1.
REQ-034 Accepted entry reg 0, data 0x12345678 -> write_enabled stays 0; commit_count_out increments by 1 (with COMMIT_COUNTER_EN).
REQ-035 Mispredict entry reg 7, target 0x00001000, FLUSH_WAIT=2 -> cycle+1 write reg 7; cycle+1 state FLUSH, cycle+2 flush_out=1, pc 0x1000; ready low for 3 cycles total after accept, then 1.
REQ-036 rdy_in=0 during WAIT for 4 cycles -> counter frozen, no flush/write pulses; WAIT resumes on rdy_in=1.
REQ-037 rst_in asserted in FLUSH cycle -> flush_out drops to 0 asynchronously; after release state RUN, rob_ready_out=1.
